// File: rtl/ifu_fetch_pkg.sv
// Shared fetch-unit types and constants (widths are also used by the decode stage).
package ifu_fetch_pkg;

  localparam int unsigned PC_W   = 64;
  localparam int unsigned INST_W = 32;

  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 64'h8000_0000;
  localparam logic [PC_W-1:0] PC_STEP          = PC_W'(4);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } fetch_state_e;

  // Redirect targets are word aligned; low two bits are ignored.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
    return {addr[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_npc_sel.sv
// Next-pc selection: redirect priority (E over D), target alignment and sequential pc+4.
module ifu_npc_sel
  import ifu_fetch_pkg::*;
(
  input  logic            e_redir_en,
  input  logic [PC_W-1:0] e_redir_npc,
  input  logic            d_byp_en,
  input  logic [PC_W-1:0] d_byp_npc,
  input  logic [PC_W-1:0] pc,
  output logic            redir_c,
  output logic [PC_W-1:0] redir_pc_c,
  output logic [PC_W-1:0] pc_inc_c
);

  // Any redirect source active this cycle.
  assign redir_c = e_redir_en | d_byp_en;

  // E-stage target wins over the decode bypass when both fire.
  assign redir_pc_c = align_pc(e_redir_en ? e_redir_npc : d_byp_npc);

  // Sequential successor; wraps naturally at 2^64.
  assign pc_inc_c = pc + PC_STEP;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch: one outstanding imem request, response capture, D-pipe handoff, redirects.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [63:0] imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  output logic        imem_rsp_ready_o,
  input  logic        e_redir_en_i,
  input  logic [63:0] e_redir_npc_i,
  input  logic        d_byp_en_i,
  input  logic [63:0] d_byp_npc_i,
  output logic        f_valid_o,
  input  logic        D_ready_i,
  output logic [31:0] inst_o,
  output logic [63:0] pc_o
);

  fetch_state_e      state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              drop_q, drop_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [PC_W-1:0]   pc_out_q, pc_out_d;

  logic              redir_c;
  logic [PC_W-1:0]   redir_pc_c;
  logic [PC_W-1:0]   pc_inc_c;
  logic              req_fire_c;
  logic              rsp_fire_c;
  logic              hand_fire_c;

  // Redirect priority, alignment and pc+4.
  ifu_npc_sel u_npc_sel (
    .e_redir_en  (e_redir_en_i),
    .e_redir_npc (e_redir_npc_i),
    .d_byp_en    (d_byp_en_i),
    .d_byp_npc   (d_byp_npc_i),
    .pc          (pc_q),
    .redir_c     (redir_c),
    .redir_pc_c  (redir_pc_c),
    .pc_inc_c    (pc_inc_c)
  );

  // Interface outputs are decoded straight from state; f_valid is squashed by a same-cycle redirect.
  assign imem_req_valid_o = (state_q == S_REQ);
  assign imem_req_addr_o  = pc_q;
  assign imem_rsp_ready_o = (state_q == S_WAIT);
  assign f_valid_o        = (state_q == S_OUT) & ~redir_c;
  assign inst_o           = inst_q;
  assign pc_o             = pc_out_q;

  assign req_fire_c  = imem_req_valid_o & imem_req_ready_i;
  assign rsp_fire_c  = imem_rsp_ready_o & imem_rsp_valid_i;
  assign hand_fire_c = f_valid_o & D_ready_i;

  // Next-state, pc, drop and capture logic; a redirect overrides every other rule.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    drop_d   = drop_q;
    inst_d   = inst_q;
    pc_out_d = pc_out_q;

    if (redir_c) begin
      pc_d = redir_pc_c;
      unique case (state_q)
        S_REQ: begin
          // Old address already accepted: its response must be thrown away.
          if (req_fire_c) begin
            state_d = S_WAIT;
            drop_d  = 1'b1;
          end
        end
        S_WAIT: begin
          if (rsp_fire_c) begin
            state_d = S_REQ;
            drop_d  = 1'b0;
          end else begin
            drop_d  = 1'b1;
          end
        end
        S_OUT: begin
          state_d = S_REQ;
        end
        default: begin
          state_d = S_REQ;
        end
      endcase
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (req_fire_c) begin
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (rsp_fire_c) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = S_REQ;
            end else begin
              inst_d   = imem_rsp_data_i;
              pc_out_d = pc_q;
              state_d  = S_OUT;
            end
          end
        end
        S_OUT: begin
          if (hand_fire_c) begin
            pc_d    = pc_inc_c;
            state_d = S_REQ;
          end
        end
        default: begin
          state_d = S_REQ;
        end
      endcase
    end
  end

  // State and datapath registers; reset abandons any in-flight request.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      drop_q   <= 1'b0;
      inst_q   <= '0;
      pc_out_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      drop_q   <= drop_d;
      inst_q   <= inst_d;
      pc_out_q <= pc_out_d;
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: streaming, stall, drop, priority, squash, async reset.
module tb_ifu_fetch;

  logic        clk_i;
  logic        rst_n_i;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [63:0] imem_req_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        imem_rsp_ready_o;
  logic        e_redir_en_i;
  logic [63:0] e_redir_npc_i;
  logic        d_byp_en_i;
  logic [63:0] d_byp_npc_i;
  logic        f_valid_o;
  logic        D_ready_i;
  logic [31:0] inst_o;
  logic [63:0] pc_o;

  int n_pass;
  int n_total;

  ifu_fetch #(.RESET_PC(64'h8000_0000)) dut (
    .clk_i            (clk_i),
    .rst_n_i          (rst_n_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .imem_rsp_ready_o (imem_rsp_ready_o),
    .e_redir_en_i     (e_redir_en_i),
    .e_redir_npc_i    (e_redir_npc_i),
    .d_byp_en_i       (d_byp_en_i),
    .d_byp_npc_i      (d_byp_npc_i),
    .f_valid_o        (f_valid_o),
    .D_ready_i        (D_ready_i),
    .inst_o           (inst_o),
    .pc_o             (pc_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Advance one cycle; inputs change 1ns after the rising edge.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    imem_req_ready_i = 1'b0; imem_rsp_valid_i = 1'b0; imem_rsp_data_i = '0;
    e_redir_en_i = 1'b0; e_redir_npc_i = '0; d_byp_en_i = 1'b0; d_byp_npc_i = '0;
    D_ready_i = 1'b0;
    #12;
    n_total++; if (imem_req_valid_o !== 1'b1) $display("FAIL reset_req_valid got=%b exp=1", imem_req_valid_o); else n_pass++;
    n_total++; if (imem_req_addr_o !== 64'h8000_0000) $display("FAIL reset_addr got=%h exp=80000000", imem_req_addr_o); else n_pass++;
    n_total++; if (imem_rsp_ready_o !== 1'b0) $display("FAIL reset_rsp_ready got=%b exp=0", imem_rsp_ready_o); else n_pass++;
    n_total++; if (f_valid_o !== 1'b0) $display("FAIL reset_f_valid got=%b exp=0", f_valid_o); else n_pass++;
    n_total++; if (inst_o !== 32'h0 || pc_o !== 64'h0) $display("FAIL reset_inst_pc got=%h/%h exp=0/0", inst_o, pc_o); else n_pass++;
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
  endtask

  // Three back-to-back fetches with a one-cycle imem and an always-ready D-pipe.
  task automatic test_stream();
    logic [63:0] exp_addr;
    logic [31:0] data;
    for (int i = 0; i < 3; i++) begin
      exp_addr = 64'h8000_0000 + 64'(4 * i);
      data = 32'h0000_0013 + 32'(i << 8);
      #1;
      n_total++; if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== exp_addr)
        $display("FAIL stream_req%0d got=%b/%h exp=1/%h", i, imem_req_valid_o, imem_req_addr_o, exp_addr); else n_pass++;
      imem_req_ready_i = 1'b1;
      cyc();
      imem_req_ready_i = 1'b0;
      imem_rsp_valid_i = 1'b1; imem_rsp_data_i = data;
      #1;
      n_total++; if (imem_rsp_ready_o !== 1'b1 || f_valid_o !== 1'b0 || imem_req_valid_o !== 1'b0)
        $display("FAIL stream_wait%0d got=rsp_rdy %b f_valid %b req %b exp=1/0/0", i, imem_rsp_ready_o, f_valid_o, imem_req_valid_o); else n_pass++;
      cyc();
      imem_rsp_valid_i = 1'b0;
      D_ready_i = 1'b1;
      #1;
      n_total++; if (f_valid_o !== 1'b1 || inst_o !== data || pc_o !== exp_addr)
        $display("FAIL stream_offer%0d got=%b/%h/%h exp=1/%h/%h", i, f_valid_o, inst_o, pc_o, data, exp_addr); else n_pass++;
      cyc();
      D_ready_i = 1'b0;
    end
  endtask

  // D-pipe back-pressure for five cycles in S_OUT.
  task automatic test_stall();
    #1;
    n_total++; if (imem_req_addr_o !== 64'h8000_000C) $display("FAIL stall_req got=%h exp=8000000c", imem_req_addr_o); else n_pass++;
    imem_req_ready_i = 1'b1;
    cyc();
    imem_req_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b1; imem_rsp_data_i = 32'hCAFE_0001;
    cyc();
    imem_rsp_valid_i = 1'b0; imem_rsp_data_i = 32'h1111_2222;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_total++; if (f_valid_o !== 1'b1 || inst_o !== 32'hCAFE_0001 || pc_o !== 64'h8000_000C || imem_req_valid_o !== 1'b0)
        $display("FAIL stall_hold%0d got=%b/%h/%h req %b exp=1/cafe0001/8000000c req 0", k, f_valid_o, inst_o, pc_o, imem_req_valid_o); else n_pass++;
      cyc();
    end
    D_ready_i = 1'b1;
    cyc();
    D_ready_i = 1'b0;
    #1;
    n_total++; if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 64'h8000_0010)
      $display("FAIL stall_release got=%b/%h exp=1/80000010", imem_req_valid_o, imem_req_addr_o); else n_pass++;
  endtask

  // Decode bypass while waiting; late response is dropped.
  task automatic test_drop();
    imem_req_ready_i = 1'b1;
    cyc();
    imem_req_ready_i = 1'b0;
    d_byp_en_i = 1'b1; d_byp_npc_i = 64'h8000_0103;
    cyc();
    d_byp_en_i = 1'b0;
    #1;
    n_total++; if (imem_rsp_ready_o !== 1'b1) $display("FAIL drop_still_wait got=%b exp=1", imem_rsp_ready_o); else n_pass++;
    cyc();
    imem_rsp_valid_i = 1'b1; imem_rsp_data_i = 32'hDEAD_BEEF;
    cyc();
    imem_rsp_valid_i = 1'b0;
    #1;
    n_total++; if (f_valid_o !== 1'b0) $display("FAIL drop_no_offer got=%b exp=0", f_valid_o); else n_pass++;
    n_total++; if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 64'h8000_0100)
      $display("FAIL drop_next_req got=%b/%h exp=1/80000100", imem_req_valid_o, imem_req_addr_o); else n_pass++;
    n_total++; if (inst_o === 32'hDEAD_BEEF) $display("FAIL drop_inst_latched got=%h exp=not deadbeef", inst_o); else n_pass++;
  endtask

  // E and D redirect together in S_REQ without acceptance: E wins.
  task automatic test_priority();
    e_redir_en_i = 1'b1; e_redir_npc_i = 64'h8000_0200;
    d_byp_en_i = 1'b1;   d_byp_npc_i = 64'h8000_0300;
    cyc();
    e_redir_en_i = 1'b0; d_byp_en_i = 1'b0;
    #1;
    n_total++; if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 64'h8000_0200)
      $display("FAIL prio_addr got=%b/%h exp=1/80000200", imem_req_valid_o, imem_req_addr_o); else n_pass++;
    // Redirect coincident with acceptance: old response discarded, then target fetched.
    imem_req_ready_i = 1'b1;
    e_redir_en_i = 1'b1; e_redir_npc_i = 64'h8000_0402;
    cyc();
    imem_req_ready_i = 1'b0; e_redir_en_i = 1'b0;
    imem_rsp_valid_i = 1'b1; imem_rsp_data_i = 32'hBAD0_0000;
    #1;
    n_total++; if (imem_rsp_ready_o !== 1'b1) $display("FAIL accept_redir_wait got=%b exp=1", imem_rsp_ready_o); else n_pass++;
    cyc();
    imem_rsp_valid_i = 1'b0;
    #1;
    n_total++; if (f_valid_o !== 1'b0 || imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 64'h8000_0400)
      $display("FAIL accept_redir_next got=%b/%b/%h exp=0/1/80000400", f_valid_o, imem_req_valid_o, imem_req_addr_o); else n_pass++;
  endtask

  // Redirect in S_OUT with D_ready=1 squashes the held instruction.
  task automatic test_squash();
    imem_req_ready_i = 1'b1;
    cyc();
    imem_req_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b1; imem_rsp_data_i = 32'h0BAD_F00D;
    cyc();
    imem_rsp_valid_i = 1'b0;
    #1;
    n_total++; if (f_valid_o !== 1'b1 || pc_o !== 64'h8000_0400) $display("FAIL squash_pre got=%b/%h exp=1/80000400", f_valid_o, pc_o); else n_pass++;
    e_redir_en_i = 1'b1; e_redir_npc_i = 64'h8000_0301; D_ready_i = 1'b1;
    #1;
    n_total++; if (f_valid_o !== 1'b0) $display("FAIL squash_fvalid got=%b exp=0", f_valid_o); else n_pass++;
    cyc();
    e_redir_en_i = 1'b0; D_ready_i = 1'b0;
    #1;
    n_total++; if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 64'h8000_0300)
      $display("FAIL squash_next got=%b/%h exp=1/80000300", imem_req_valid_o, imem_req_addr_o); else n_pass++;
  endtask

  // Asynchronous reset pulse while waiting for a response.
  task automatic test_async_reset();
    imem_req_ready_i = 1'b1;
    cyc();
    imem_req_ready_i = 1'b0;
    #2;
    rst_n_i = 1'b0;
    #1;
    n_total++; if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 64'h8000_0000 || imem_rsp_ready_o !== 1'b0)
      $display("FAIL arst_state got=%b/%h/%b exp=1/80000000/0", imem_req_valid_o, imem_req_addr_o, imem_rsp_ready_o); else n_pass++;
    n_total++; if (pc_o !== 64'h0 || inst_o !== 32'h0) $display("FAIL arst_out got=%h/%h exp=0/0", pc_o, inst_o); else n_pass++;
    cyc();
    rst_n_i = 1'b1;
    // A clean transaction must be offered, proving no stale drop record.
    imem_req_ready_i = 1'b1;
    cyc();
    imem_req_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b1; imem_rsp_data_i = 32'h0000_0073;
    cyc();
    imem_rsp_valid_i = 1'b0;
    #1;
    n_total++; if (f_valid_o !== 1'b1 || inst_o !== 32'h0000_0073 || pc_o !== 64'h8000_0000)
      $display("FAIL arst_refetch got=%b/%h/%h exp=1/00000073/80000000", f_valid_o, inst_o, pc_o); else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    test_reset();
    test_stream();
    test_stall();
    test_drop();
    test_priority();
    test_squash();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
